reg_file_scoreboard: RTL and testbench
======================================

# reg_file_scoreboard

Register file with integrated write-pending scoreboard. It is the consumer of the write-back stage: it takes the selected write-back word (memory data, execution result or link value) and commits it to the architectural registers. It serves the decode stage with two bypassed read ports and a combinational issue stall that blocks RAW and WAW hazards against writes still in flight.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers, index 0 hardwired zero

- iClk  input  1  clock, all state updates on rising edge
- iRst  input  1  asynchronous, active-high reset
- iRdAddrA  input  ADDR_WIDTH  source A index
- iRdAddrB  input  ADDR_WIDTH  source B index
- iRdEnA  input  1  instruction uses source A (hazard check enable)
- iRdEnB  input  1  instruction uses source B
- oRdDataA  output  DATA_WIDTH  source A data, combinational, bypassed
- oRdDataB  output  DATA_WIDTH  source B data, combinational, bypassed
- iIssueValid  input  1  decode presents an instruction this cycle
- iIssueWrites  input  1  presented instruction writes a destination
- iIssueDest  input  ADDR_WIDTH  destination index
- oStall  output  1  combinational; issue not accepted this cycle
- iWbValid  input  1  write-back strobe
- iWbAddr  input  ADDR_WIDTH  write-back index
- iWbData  input  DATA_WIDTH  write-back word from the write-back mux
- oBusyMask  output  2**ADDR_WIDTH  registered pending bit per register
- oPendingCount  output  ADDR_WIDTH+1  registered count of set pending bits
- oWbOrphan  output  1  sticky: write-back hit a register with no pending bit

## Operation
- State: register array, pending vector, pending counter, orphan flag.
- wbHit = iWbValid & (iWbAddr != 0).
- pendEff[i] = pending[i] & ~(wbHit & iWbAddr == i); a same-cycle write-back retires the hazard.
- Read: index 0 returns 0; else if wbHit and iWbAddr equals read index, return iWbData; else array value.
- oStall = iIssueValid & ((iRdEnA & pendEff[iRdAddrA]) | (iRdEnB & pendEff[iRdAddrB]) | (iIssueWrites & pendEff[iIssueDest])). Index 0 is never pending, so it never stalls.
- Accepted issue: iIssueValid & ~oStall.
- setHit = accepted issue & iIssueWrites & (iIssueDest != 0).
- Write-back, on edge: if wbHit, array[iWbAddr] <= iWbData and pending[iWbAddr] <= 0. iWbAddr 0 is ignored entirely.
- Orphan: if wbHit and pending[iWbAddr] == 0, oWbOrphan <= 1 and holds until reset. The data write still occurs.
- Issue, on edge: if setHit, pending[iIssueDest] <= 1. Set has priority over a clear of the same index in the same cycle.
- Counter: +1 if setHit, -1 if wbHit and pending[iWbAddr] was 1.
  - Same index, both events: counter unchanged and bit stays 1.
  - Orphan write-back: no decrement.
  - Counter always equals popcount(pending) and never exceeds 2**ADDR_WIDTH-1.

## Timing
- Reset (async, any time, including mid-operation): all registers 0, pending 0, oPendingCount 0, oWbOrphan 0.
  - oBusyMask is 0 immediately.
  - oRdData reads 0 unless bypass from a live iWbValid.
  - Any in-flight write-back that coincides with reset is discarded.
- Write-back latency: array commit at the edge. Same-cycle readers see the data through the bypass; later readers see it from the array.
- Pending set: visible in oBusyMask/oStall from the cycle after the accepted issue.
- oStall depends combinationally on iWb*. The write-back stage must not depend combinationally on oStall (no loop).
- Held instruction: decode holds iIssue*/iRdAddr* while oStall=1. It is accepted in the first cycle its hazard retires, which can be the same cycle as the matching write-back.

## Test plan
- Reset, write-back r5=0x0000_1234 with pending clear -> next cycle read A=5 gives 0x1234; oWbOrphan=1; oPendingCount=0.
- Issue dest r3 (accepted) -> oBusyMask[3]=1, count=1. Next instruction reads r3 with iRdEnA=1 -> oStall=1 until iWbValid r3=0xDEADBEEF. In that cycle oStall=0 and oRdDataA=0xDEADBEEF. Afterwards count=0 and no orphan.
- Write-back r0=0xFFFF_FFFF -> read r0 stays 0, no orphan, count unchanged; issue dest r0 never sets pending or stalls.
- Same-cycle write-back r7 and accepted issue dest r7 with r7 pending -> r7 stays pending, count unchanged, array[7] updated.
- Issue 31 distinct dests r1..r31 -> count=31 and mask=0xFFFF_FFFE. Issuing dest r9 again -> WAW stall until r9 is written back.
- Assert iRst mid-sequence with 4 pending -> mask, count and orphan read 0 asynchronously; previously written registers read 0.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Register file with a write-pending scoreboard. Write-back commits data and
// retires the pending bit; decode reads two bypassed ports and sees a
// combinational stall for RAW/WAW hazards against writes still in flight.
module reg_file_scoreboard #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                    iClk,
   input  logic                    iRst,
   input  logic [ADDR_WIDTH-1:0]   iRdAddrA,
   input  logic [ADDR_WIDTH-1:0]   iRdAddrB,
   input  logic                    iRdEnA,
   input  logic                    iRdEnB,
   output logic [DATA_WIDTH-1:0]   oRdDataA,
   output logic [DATA_WIDTH-1:0]   oRdDataB,
   input  logic                    iIssueValid,
   input  logic                    iIssueWrites,
   input  logic [ADDR_WIDTH-1:0]   iIssueDest,
   output logic                    oStall,
   input  logic                    iWbValid,
   input  logic [ADDR_WIDTH-1:0]   iWbAddr,
   input  logic [DATA_WIDTH-1:0]   iWbData,
   output logic [2**ADDR_WIDTH-1:0] oBusyMask,
   output logic [ADDR_WIDTH:0]     oPendingCount,
   output logic                    oWbOrphan
);

   localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NumRegs];
   logic [NumRegs-1:0]    pend_q, pend_d, pend_eff;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  orphan_q, orphan_d;
   logic                  wb_hit, wb_retire, accept, set_hit;

   // Write-back to r0 is ignored; a live write-back retires its hazard this cycle.
   always_comb begin
      wb_hit    = iWbValid & (iWbAddr != '0);
      wb_retire = wb_hit & pend_q[iWbAddr];
      pend_eff  = pend_q;
      if (wb_hit) begin
         pend_eff[iWbAddr] = 1'b0;
      end
   end

   // Bypassed read ports; r0 always reads zero.
   always_comb begin
      oRdDataA = regs_q[iRdAddrA];
      if (wb_hit && (iWbAddr == iRdAddrA)) begin
         oRdDataA = iWbData;
      end
      if (iRdAddrA == '0) begin
         oRdDataA = '0;
      end
      oRdDataB = regs_q[iRdAddrB];
      if (wb_hit && (iWbAddr == iRdAddrB)) begin
         oRdDataB = iWbData;
      end
      if (iRdAddrB == '0) begin
         oRdDataB = '0;
      end
   end

   // Issue stall on RAW (either source) or WAW (destination) against pending writes.
   always_comb begin
      oStall  = iIssueValid & ((iRdEnA & pend_eff[iRdAddrA]) |
                               (iRdEnB & pend_eff[iRdAddrB]) |
                               (iIssueWrites & pend_eff[iIssueDest]));
      accept  = iIssueValid & ~oStall;
      set_hit = accept & iIssueWrites & (iIssueDest != '0);
   end

   // Next-state for the scoreboard; a set wins over a same-index clear.
   always_comb begin
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      orphan_d = orphan_q | (wb_hit & ~pend_q[iWbAddr]);
      if (wb_hit) begin
         pend_d[iWbAddr] = 1'b0;
      end
      if (set_hit) begin
         pend_d[iIssueDest] = 1'b1;
      end
      unique case ({set_hit, wb_retire})
         2'b10:   cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
         2'b01:   cnt_d = cnt_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
         default: cnt_d = cnt_q;
      endcase
   end

   // Scoreboard state registers.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         pend_q   <= '0;
         cnt_q    <= '0;
         orphan_q <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         orphan_q <= orphan_d;
      end
   end

   // Register array; commit happens on the edge, orphan writes included.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         for (int unsigned i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_hit) begin
         regs_q[iWbAddr] <= iWbData;
      end
   end

   assign oBusyMask     = pend_q;
   assign oPendingCount = cnt_q;
   assign oWbOrphan     = orphan_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: the driver pushes expected
// responses from an array-based reference model, a negedge monitor compares.
module tb_reg_file_scoreboard;

   localparam int NR = 32;

   logic        iClk = 1'b0;
   logic        iRst;
   logic [4:0]  iRdAddrA, iRdAddrB, iIssueDest, iWbAddr;
   logic        iRdEnA, iRdEnB, iIssueValid, iIssueWrites, iWbValid;
   logic [31:0] iWbData;
   logic [31:0] oRdDataA, oRdDataB;
   logic        oStall, oWbOrphan;
   logic [31:0] oBusyMask;
   logic [5:0]  oPendingCount;

   always #5 iClk = ~iClk;

   reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .iClk(iClk), .iRst(iRst),
      .iRdAddrA(iRdAddrA), .iRdAddrB(iRdAddrB), .iRdEnA(iRdEnA), .iRdEnB(iRdEnB),
      .oRdDataA(oRdDataA), .oRdDataB(oRdDataB),
      .iIssueValid(iIssueValid), .iIssueWrites(iIssueWrites), .iIssueDest(iIssueDest),
      .oStall(oStall),
      .iWbValid(iWbValid), .iWbAddr(iWbAddr), .iWbData(iWbData),
      .oBusyMask(oBusyMask), .oPendingCount(oPendingCount), .oWbOrphan(oWbOrphan)
   );

   // Reference model: architectural values, pending flags, sticky orphan.
   logic [31:0] m_regs [NR];
   bit          m_pend [NR];
   bit          m_orph;

   typedef struct {
      logic        stall;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] mask;
      logic [5:0]  cnt;
      logic        orph;
   } exp_t;

   exp_t q[$];
   int   n_err = 0;
   int   n_chk = 0;
   bit   last_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit wb_live();
      return iWbValid && (iWbAddr != 5'd0);
   endfunction

   // A register blocks issue if it is pending and not being written back right now.
   function automatic bit hazard(input logic [4:0] i);
      return (i != 5'd0) && m_pend[i] && !(wb_live() && (iWbAddr == i));
   endfunction

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_live() && (iWbAddr == a)) return iWbData;
      return m_regs[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = 32'd0;
         m_pend[i] = 1'b0;
      end
      m_orph = 1'b0;
   endtask

   task automatic drv(input bit iv, input bit w, input logic [4:0] d,
                      input bit ea, input logic [4:0] ra, input bit eb, input logic [4:0] rb,
                      input bit wv, input logic [4:0] wa, input logic [31:0] wd);
      iIssueValid = iv; iIssueWrites = w; iIssueDest = d;
      iRdEnA = ea; iRdAddrA = ra; iRdEnB = eb; iRdAddrB = rb;
      iWbValid = wv; iWbAddr = wa; iWbData = wd;
   endtask

   task automatic idle();
      drv(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
   endtask

   // Called at posedge+1 with inputs applied: queue the expectation, advance the model.
   task automatic do_cycle();
      exp_t e;
      int   c;
      c = 0;
      e.stall = iIssueValid && ((iRdEnA && hazard(iRdAddrA)) || (iRdEnB && hazard(iRdAddrB)) ||
                                (iIssueWrites && hazard(iIssueDest)));
      e.a = model_rd(iRdAddrA);
      e.b = model_rd(iRdAddrB);
      for (int i = 0; i < NR; i++) begin
         e.mask[i] = m_pend[i];
         if (m_pend[i]) c++;
      end
      e.cnt  = 6'(c);
      e.orph = m_orph;
      q.push_back(e);
      last_stall = e.stall;
      if (wb_live()) begin
         if (!m_pend[iWbAddr]) m_orph = 1'b1;
         m_regs[iWbAddr] = iWbData;
         m_pend[iWbAddr] = 1'b0;
      end
      if (iIssueValid && !e.stall && iIssueWrites && (iIssueDest != 5'd0)) begin
         m_pend[iIssueDest] = 1'b1;
      end
      @(posedge iClk);
      #1;
   endtask

   // Mid-cycle asynchronous reset with an optional live write-back on port A.
   task automatic pulse_reset(input bit wv, input logic [4:0] wa, input logic [31:0] wd);
      #2;
      idle();
      iWbValid = wv; iWbAddr = wa; iWbData = wd; iRdEnA = 1'b1; iRdAddrA = wa;
      iRst = 1'b1;
      #1;
      chk("rst_mask", oBusyMask, 32'd0);
      chk("rst_count", {26'd0, oPendingCount}, 32'd0);
      chk("rst_orphan", {31'd0, oWbOrphan}, 32'd0);
      chk("rst_rdA", oRdDataA, (wv && wa != 5'd0) ? wd : 32'd0);
      iWbValid = 1'b0;
      #1;
      iRst = 1'b0;
      model_reset();
      idle();
      @(posedge iClk);
      #1;
   endtask

   // Monitor: compare every queued expectation against the DUT mid-cycle.
   always @(negedge iClk) begin
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk("stall", {31'd0, oStall}, {31'd0, e.stall});
         chk("rdA", oRdDataA, e.a);
         chk("rdB", oRdDataB, e.b);
         chk("busy_mask", oBusyMask, e.mask);
         chk("pend_count", {26'd0, oPendingCount}, {26'd0, e.cnt});
         chk("orphan", {31'd0, oWbOrphan}, {31'd0, e.orph});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] pick;
      bit         held;
      iRst = 1'b1;
      idle();
      model_reset();
      repeat (2) @(posedge iClk);
      #1;
      iRst = 1'b0;
      do_cycle();

      // Orphan write-back, then read it back from the array.
      drv(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd5, 32'h0000_1234);
      do_cycle();
      drv(0, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 5'd0, 32'd0);
      do_cycle();
      chk("r5_array", oRdDataA, 32'h0000_1234);

      // RAW stall on r3 released by the matching write-back with bypass.
      pulse_reset(0, 5'd0, 32'd0);
      drv(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
      do_cycle();
      drv(1, 0, 5'd0, 1, 5'd3, 0, 5'd0, 0, 5'd0, 32'd0);
      do_cycle();
      do_cycle();
      drv(1, 0, 5'd0, 1, 5'd3, 0, 5'd0, 1, 5'd3, 32'hDEAD_BEEF);
      do_cycle();
      idle();
      do_cycle();

      // r0 is inert for write-back, reads and issue.
      drv(0, 0, 5'd0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 32'hFFFF_FFFF);
      do_cycle();
      drv(1, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
      do_cycle();
      idle();
      do_cycle();

      // Same-cycle write-back and re-issue of r7 keeps it pending.
      drv(1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
      do_cycle();
      drv(1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 1, 5'd7, 32'hA5A5_0007);
      do_cycle();
      drv(0, 0, 5'd0, 1, 5'd7, 0, 5'd0, 0, 5'd0, 32'd0);
      do_cycle();

      // Fill every register, then a WAW stall on r9.
      pulse_reset(0, 5'd0, 32'd0);
      for (int d = 1; d < NR; d++) begin
         drv(1, 1, 5'(d), 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
         do_cycle();
      end
      idle();
      do_cycle();
      chk("full_mask", oBusyMask, 32'hFFFF_FFFE);
      drv(1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
      do_cycle();
      do_cycle();
      drv(1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 1, 5'd9, 32'h0000_0909);
      do_cycle();
      idle();
      do_cycle();

      // Async reset with four pending and a write-back in flight.
      pulse_reset(0, 5'd0, 32'd0);
      drv(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 5'd10, 32'h0000_1010);
      do_cycle();
      for (int k = 1; k <= 4; k++) begin
         drv(1, 1, 5'(2 * k), 0, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0);
         do_cycle();
      end
      idle();
      do_cycle();
      pulse_reset(1, 5'd10, 32'h0000_CAFE);
      drv(0, 0, 5'd0, 1, 5'd10, 1, 5'd4, 0, 5'd0, 32'd0);
      do_cycle();

      // Randomised traffic; decode holds a stalled instruction.
      held = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            pulse_reset(0, 5'd0, 32'd0);
            held = 1'b0;
         end
         if (!held) begin
            iIssueValid  = 1'($urandom_range(0, 1));
            iIssueWrites = 1'($urandom_range(0, 3) != 0);
            iIssueDest   = 5'($urandom_range(0, 31));
            iRdEnA       = 1'($urandom_range(0, 1));
            iRdAddrA     = 5'($urandom_range(0, 31));
            iRdEnB       = 1'($urandom_range(0, 1));
            iRdAddrB     = 5'($urandom_range(0, 31));
         end
         iWbValid = 1'($urandom_range(0, 9) < 4);
         iWbData  = $urandom;
         pick     = 5'($urandom_range(0, 31));
         iWbAddr  = pick;
         if ($urandom_range(0, 7) != 0) begin
            for (int j = 0; j < NR; j++) begin
               if (m_pend[5'(pick + 5'(j))]) begin
                  iWbAddr = 5'(pick + 5'(j));
                  break;
               end
            end
         end
         do_cycle();
         held = last_stall;
      end

      idle();
      do_cycle();
      @(negedge iClk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
